// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg -- constants and helpers shared by the fetch stage.
//
// Contents:
//   PC_W           program-counter / instruction width
//   HLT_OPCODE     opcode nibble of the halt instruction
//   BHT_ENTRIES    number of branch-history / target entries
//   BHT_IDX_W      index width derived from BHT_ENTRIES
//   BHT_CNT_RESET  2-bit counter value after reset (weakly not-taken)
//   bht_next()     saturating 2-bit counter step
package pc_fetch_unit_pkg;

  localparam int unsigned PC_W        = 16;
  localparam logic [3:0]  HLT_OPCODE  = 4'hF;
  localparam int unsigned BHT_ENTRIES = 8;
  localparam int unsigned BHT_IDX_W   = $clog2(BHT_ENTRIES);

  typedef enum logic [1:0] {
    BHT_STRONG_NT = 2'b00,
    BHT_WEAK_NT   = 2'b01,
    BHT_WEAK_T    = 2'b10,
    BHT_STRONG_T  = 2'b11
  } bht_state_e;

  localparam logic [1:0] BHT_CNT_RESET = BHT_WEAK_NT;

  // Move a 2-bit counter one step toward taken (11) or not-taken (00),
  // sticking at either end.
  function automatic logic [1:0] bht_next(input logic [1:0] cnt,
                                          input logic       taken);
    if (taken)
      return (cnt == BHT_STRONG_T)  ? cnt : cnt + 2'd1;
    else
      return (cnt == BHT_STRONG_NT) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/CPU_Register.sv
// CPU_Register -- generic enabled register with asynchronous active-high reset.
//
// Parameters:
//   WIDTH      register width
//   RESET_VAL  value loaded while rst is high
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous reset, active-high
//   en   in   load enable; q holds when low
//   d    in   next value
//   q    out  registered value
module CPU_Register #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: clocked state is assigned with <= so every register samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= RESET_VAL;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/pc_fetch_unit_branch_predictor.sv
// branch_predictor -- combined BHT (2-bit counters) and BTB (target + valid).
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   asynchronous reset, active-high
//   rd_idx          in   entry looked up for the instruction being fetched
//   predicted_taken out  counter MSB of rd_idx AND its valid bit
//   pred_target     out  stored target of rd_idx
//   update          in   train entry upd_idx this cycle
//   upd_idx         in   entry trained
//   actual_taken    in   resolved direction
//   actual_target   in   resolved target (written only when taken)
//
// Reads are combinational from the registered arrays, so a read of an entry
// being trained in the same cycle returns its pre-update contents.
module branch_predictor
  import pc_fetch_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic                 predicted_taken,
  output logic [PC_W-1:0]      pred_target,
  input  logic                 update,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 actual_taken,
  input  logic [PC_W-1:0]      actual_target
);

  logic [BHT_ENTRIES-1:0][1:0]      bht_q;
  logic [BHT_ENTRIES-1:0][PC_W-1:0] target_q;
  logic [BHT_ENTRIES-1:0]           valid_q;

  // NOTE: these arrays are cleared by reset on purpose -- a prediction made
  // from stale entries would redirect fetch, so they cannot be left as
  // uninitialised RAM the way a data buffer could.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i]    <= BHT_CNT_RESET;
        target_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (update) begin
      bht_q[upd_idx] <= bht_next(bht_q[upd_idx], actual_taken);
      if (actual_taken) begin
        target_q[upd_idx] <= actual_target;
        valid_q[upd_idx]  <= 1'b1;
      end
    end
  end

  assign predicted_taken = bht_q[rd_idx][1] & valid_q[rd_idx];
  assign pred_target     = target_q[rd_idx];

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit -- instruction-fetch program counter with optional dynamic
// branch prediction.
//
// Build option:
//   DYNAMIC_BP_EN  defined: 8-entry BHT/BTB predicts the next PC.
//                  undefined: no predictor storage, next PC is always PC+2.
//
// Parameters:
//   RESET_PC         PC value loaded on reset
// Ports:
//   clk              in   rising-edge clock
//   rst              in   asynchronous reset, active-high
//   stall            in   hold PC (shared with the IF/ID stall)
//   mispredicted     in   redirect fetch to correct_PC next edge
//   correct_PC       in   redirect address
//   update           in   train predictor with a resolved branch
//   update_PC_idx    in   low PC bits of the resolved branch
//   actual_taken     in   resolved direction
//   actual_target    in   resolved target
//   imem_rdata       in   instruction word at imem_addr (combinational)
//   imem_addr        out  instruction address (= PC_curr)
//   PC_curr          out  current fetch PC
//   PC_next          out  predicted next PC
//   PC_inst          out  fetched instruction word (= imem_rdata)
//   predicted_taken  out  prediction for the instruction at PC_curr
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            mispredicted,
  input  logic [PC_W-1:0] correct_PC,
  input  logic            update,
  input  logic [3:0]      update_PC_idx,
  input  logic            actual_taken,
  input  logic [PC_W-1:0] actual_target,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] PC_curr,
  output logic [PC_W-1:0] PC_next,
  output logic [PC_W-1:0] PC_inst,
  output logic            predicted_taken
);

  logic [PC_W-1:0] pc_plus2;
  logic [PC_W-1:0] pc_load;
  logic            halt;
  logic            pc_en;

  assign pc_plus2  = PC_curr + 16'd2;
  assign imem_addr = PC_curr;
  assign PC_inst   = imem_rdata;
  assign halt      = (imem_rdata[15:12] == HLT_OPCODE);

  // A redirect beats both stall and halt; otherwise either one freezes fetch.
  assign pc_en   = mispredicted | ~(stall | halt);
  assign pc_load = mispredicted ? correct_PC : PC_next;

  CPU_Register #(
    .WIDTH     (PC_W),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_load),
    .q   (PC_curr)
  );

`ifdef DYNAMIC_BP_EN
  logic [PC_W-1:0] pred_target;
  logic            unused_upd_lsb;

  // Instructions are halfword aligned, so bit 0 never selects an entry.
  branch_predictor u_bp (
    .clk             (clk),
    .rst             (rst),
    .rd_idx          (PC_curr[BHT_IDX_W:1]),
    .predicted_taken (predicted_taken),
    .pred_target     (pred_target),
    .update          (update),
    .upd_idx         (update_PC_idx[BHT_IDX_W:1]),
    .actual_taken    (actual_taken),
    .actual_target   (actual_target)
  );

  assign PC_next        = predicted_taken ? pred_target : pc_plus2;
  assign unused_upd_lsb = update_PC_idx[0];
`else
  logic unused_bp_inputs;

  assign predicted_taken  = 1'b0;
  assign PC_next          = pc_plus2;
  assign unused_bp_inputs = ^{update, update_PC_idx, actual_taken, actual_target};
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit -- self-checking bench for pc_fetch_unit.
// A behavioural model (PC value plus per-entry counter/target/valid arrays)
// is stepped on every clock edge; a compare process checks every DUT output
// against it on each falling edge. Directed steps pin the model with literal
// expectations, then randomized traffic runs with a mid-cycle reset.
module tb_pc_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef DYNAMIC_BP_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        mispredicted = 1'b0;
  logic [15:0] correct_PC = '0;
  logic        update = 1'b0;
  logic [3:0]  update_PC_idx = '0;
  logic        actual_taken = 1'b0;
  logic [15:0] actual_target = '0;
  logic [15:0] imem_rdata;
  logic [15:0] imem_addr, PC_curr, PC_next, PC_inst;
  logic        predicted_taken;

  logic        hlt_en = 1'b0;
  logic        cmp_en = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Behavioural model state
  logic [15:0] m_pc;
  int          m_cnt   [8];
  logic [15:0] m_tgt   [8];
  bit          m_valid [8];
  logic [15:0] m_word, m_nxt;
  int          m_i;

  pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .mispredicted    (mispredicted),
    .correct_PC      (correct_PC),
    .update          (update),
    .update_PC_idx   (update_PC_idx),
    .actual_taken    (actual_taken),
    .actual_target   (actual_target),
    .imem_rdata      (imem_rdata),
    .imem_addr       (imem_addr),
    .PC_curr         (PC_curr),
    .PC_next         (PC_next),
    .PC_inst         (PC_inst),
    .predicted_taken (predicted_taken)
  );

  always #5 clk = ~clk;

  // Instruction memory image: a HLT word at every address whose bits [4:1]
  // are 4'hA while hlt_en is set, otherwise an ordinary instruction.
  function automatic logic [15:0] imem_word(input logic [15:0] a);
    return (hlt_en && a[4:1] == 4'hA) ? 16'hF000 : {4'h1, a[11:0]};
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_pt();
    int k;
    k = int'(m_pc[3:1]);
    return BP_EN && m_valid[k] && (m_cnt[k] >= 2);
  endfunction

  function automatic logic [15:0] exp_next();
    int k;
    k = int'(m_pc[3:1]);
    return exp_pt() ? m_tgt[k] : m_pc + 16'd2;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC;
    for (int k = 0; k < 8; k++) begin
      m_cnt[k]   = 1;
      m_tgt[k]   = 16'h0000;
      m_valid[k] = 1'b0;
    end
  endtask

  // Model step: next PC from priority rules, then counter/target training.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      m_word = imem_word(m_pc);
      m_nxt  = exp_next();
      if (mispredicted)
        m_pc = correct_PC;
      else if (!stall && m_word[15:12] != 4'hF)
        m_pc = m_nxt;
      if (update) begin
        m_i = int'(update_PC_idx[3:1]);
        if (actual_taken) begin
          m_cnt[m_i]   = (m_cnt[m_i] < 3) ? m_cnt[m_i] + 1 : 3;
          m_tgt[m_i]   = actual_target;
          m_valid[m_i] = 1'b1;
        end else begin
          m_cnt[m_i] = (m_cnt[m_i] > 0) ? m_cnt[m_i] - 1 : 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_PC_curr",   PC_curr,   m_pc);
      check("cmp_imem_addr", imem_addr, m_pc);
      check("cmp_PC_next",   PC_next,   exp_next());
      check("cmp_pred",      16'(predicted_taken), 16'(exp_pt()));
      check("cmp_PC_inst",   PC_inst,   imem_word(m_pc));
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) next_cyc();
    check("rst_pc",   PC_curr, RESET_PC);
    check("rst_next", PC_next, RESET_PC + 16'd2);
    check("rst_pred", 16'(predicted_taken), 16'h0000);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Free-running fetch
    check("run_pc0", PC_curr, 16'h0000);
    next_cyc();
    check("run_pc1", PC_curr, 16'h0002);
    next_cyc();
    check("run_pc2", PC_curr, 16'h0004);
    check("run_pred", 16'(predicted_taken), 16'h0000);

    // Stall holds, redirect wins over stall
    stall = 1'b1;
    next_cyc();
    next_cyc();
    check("stall_hold", PC_curr, 16'h0004);
    mispredicted = 1'b1;
    correct_PC   = 16'h0040;
    next_cyc();
    check("redirect_in_stall", PC_curr, 16'h0040);
    mispredicted = 1'b0;
    stall        = 1'b0;

    // Two taken updates on idx 4 (entry 2): counter 01 -> 11
    update        = 1'b1;
    update_PC_idx = 4'h4;
    actual_taken  = 1'b1;
    actual_target = 16'h0100;
    next_cyc();
    next_cyc();
    update       = 1'b0;
    mispredicted = 1'b1;
    correct_PC   = 16'h0004;
    next_cyc();
    check("trained_pred", 16'(predicted_taken), 16'(BP_EN));
    check("trained_next", PC_next, BP_EN ? 16'h0100 : 16'h0006);

    // Not-taken updates while stalled at 0x0004: 11 -> 10 -> 01 -> 00 -> 00
    mispredicted = 1'b0;
    stall        = 1'b1;
    update       = 1'b1;
    actual_taken = 1'b0;
    next_cyc();
    check("nt1_pred", 16'(predicted_taken), 16'(BP_EN));
    next_cyc();
    next_cyc();
    check("nt3_pred", 16'(predicted_taken), 16'h0000);
    check("nt3_next", PC_next, 16'h0006);
    next_cyc();
    // One taken step from a saturated 00 must land on 01 (still not taken).
    actual_taken  = 1'b1;
    actual_target = 16'h0100;
    next_cyc();
    update = 1'b0;
    check("sat_low_pred", 16'(predicted_taken), 16'h0000);

    // Wrap at 0xFFFE
    stall        = 1'b0;
    mispredicted = 1'b1;
    correct_PC   = 16'hFFFE;
    next_cyc();
    mispredicted = 1'b0;
    check("wrap_next", PC_next, 16'h0000);
    next_cyc();
    check("wrap_pc", PC_curr, 16'h0000);

    // HLT freezes fetch until a redirect
    hlt_en       = 1'b1;
    mispredicted = 1'b1;
    correct_PC   = 16'h0014;
    next_cyc();
    mispredicted = 1'b0;
    check("hlt_inst", PC_inst, 16'hF000);
    repeat (3) next_cyc();
    check("hlt_hold", PC_curr, 16'h0014);
    mispredicted = 1'b1;
    correct_PC   = 16'h0020;
    next_cyc();
    mispredicted = 1'b0;
    hlt_en       = 1'b0;
    check("hlt_exit", PC_curr, 16'h0020);

    // Train entry 0, then reset mid-cycle while it would predict taken
    update        = 1'b1;
    update_PC_idx = 4'h0;
    actual_taken  = 1'b1;
    actual_target = 16'h0300;
    next_cyc();
    next_cyc();
    update       = 1'b0;
    mispredicted = 1'b1;
    correct_PC   = 16'h0000;
    next_cyc();
    check("e0_pred", 16'(predicted_taken), 16'(BP_EN));
    check("e0_next", PC_next, BP_EN ? 16'h0300 : 16'h0002);
    correct_PC = 16'h0008;
    next_cyc();
    mispredicted = 1'b0;
    check("pre_rst_pc", PC_curr, 16'h0008);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pc",   PC_curr, RESET_PC);
    check("async_rst_pred", 16'(predicted_taken), 16'h0000);
    check("async_rst_next", PC_next, RESET_PC + 16'd2);
    next_cyc();
    rst = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      stall         = ($urandom_range(0, 3) == 0);
      mispredicted  = ($urandom_range(0, 11) == 0);
      correct_PC    = 16'($urandom_range(0, 65535)) & 16'hFFFE;
      update        = ($urandom_range(0, 4) < 2);
      update_PC_idx = 4'($urandom_range(0, 15));
      actual_taken  = ($urandom_range(0, 2) != 0);
      actual_target = 16'($urandom_range(0, 65535)) & 16'hFFFE;
      if (c % 64 == 0)
        hlt_en = ($urandom_range(0, 3) == 0);
      if (c == 300) begin
        #2;
        rst = 1'b1;
        #1;
        check("rand_rst_pc", PC_curr, RESET_PC);
        next_cyc();
        rst = 1'b0;
      end else begin
        next_cyc();
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
